// File: rtl/sensor_buzzer_scheduler_if.sv
// sensor_buzzer_scheduler_if: groups the sensor inputs and buzzer-side outputs of the scheduler.
// Signals: sensorpin1..3 (sensor levels), buzzerpin (buzzer drive), active_sensor (burst owner), busy.
// master drives the sensors and observes the buzzer side; slave is the scheduler itself.
interface sensor_buzzer_scheduler_if;
    logic       sensorpin1;
    logic       sensorpin2;
    logic       sensorpin3;
    logic       buzzerpin;
    logic [1:0] active_sensor;
    logic       busy;
    modport master (output sensorpin1, sensorpin2, sensorpin3, input buzzerpin, active_sensor, busy);
    modport slave (input sensorpin1, sensorpin2, sensorpin3, output buzzerpin, active_sensor, busy);
endinterface

// File: rtl/sensor_buzzer_scheduler.sv
// sensor_buzzer_scheduler: shares one buzzer among three obstacle sensors using per-sensor beep counts.
// Ports: clk; rst (asynchronous, active-high); bus (slave modport): sensorpin1..3 in,
//        buzzerpin / active_sensor / busy out, all outputs registered.
// Optional feature macro STICK_DEBOUNCE_EN: when defined, each synchronized sensor is debounced
// over DEBOUNCE_CYCLES cycles; otherwise the synchronized level feeds arbitration directly.
module sensor_buzzer_scheduler #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ON_CYCLES       = 3,
    parameter int OFF_CYCLES      = 2,
    parameter int GAP_CYCLES      = 5
) (
    input logic clk,
    input logic rst,
    sensor_buzzer_scheduler_if.slave bus
);
    localparam int MAX_OO = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
    localparam int MAXC   = MAX_OO > GAP_CYCLES ? MAX_OO : GAP_CYCLES;
    localparam int PW     = $clog2(MAXC + 1);
    typedef enum logic [1:0] {IDLE, BEEP_ON, BEEP_OFF, GAP} state_t;
    if (DEBOUNCE_CYCLES < 1 || ON_CYCLES < 1 || OFF_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad
        $error("sensor_buzzer_scheduler: all cycle parameters must be >= 1");
    end
    logic [2:0] meta, sync, level;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= {bus.sensorpin3, bus.sensorpin2, bus.sensorpin1};
            sync <= meta;
        end
    end
`ifdef STICK_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          lvl;
        // cnt counts consecutive cycles the synchronized input disagrees with lvl
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                cnt <= '0;
                lvl <= sync[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign level[i] = lvl;
    end
`else
    assign level = sync;
`endif
    logic [1:0] pick;
    assign pick = level[0] ? 2'd1 : level[1] ? 2'd2 : level[2] ? 2'd3 : 2'd0;
    state_t        state, state_n;
    logic [PW-1:0] phase, phase_n;
    logic [1:0]    beeps_left, beeps_n, owner, owner_n;
    logic          buzz, busy_r;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            beeps_left <= '0;
            owner      <= '0;
            buzz       <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            beeps_left <= beeps_n;
            owner      <= owner_n;
            buzz       <= state_n == BEEP_ON;
            busy_r     <= state_n != IDLE;
        end
    end
    // phase counts down from (cycles-1) loaded on each state entry; leaving when it hits 0
    always_comb begin
        state_n = state;
        phase_n = phase - 1'b1;
        beeps_n = beeps_left;
        owner_n = owner;
        case (state)
            IDLE: begin
                phase_n = '0;
                if (pick != 2'd0) begin
                    state_n = BEEP_ON;
                    phase_n = PW'(ON_CYCLES - 1);
                    beeps_n = pick;
                    owner_n = pick;
                end
            end
            BEEP_ON: if (phase == '0) begin
                state_n = BEEP_OFF;
                phase_n = PW'(OFF_CYCLES - 1);
                beeps_n = beeps_left - 2'd1;
            end
            BEEP_OFF: if (phase == '0) begin
                state_n = beeps_left != 2'd0 ? BEEP_ON : GAP;
                phase_n = beeps_left != 2'd0 ? PW'(ON_CYCLES - 1) : PW'(GAP_CYCLES - 1);
            end
            default: if (phase == '0) begin
                state_n = IDLE;
                phase_n = '0;
                owner_n = 2'd0;
            end
        endcase
    end
    assign bus.buzzerpin     = buzz;
    assign bus.active_sensor = owner;
    assign bus.busy          = busy_r;
endmodule

// File: tb/tb_sensor_buzzer_scheduler.sv
// tb_sensor_buzzer_scheduler: scoreboard bench for sensor_buzzer_scheduler (default parameters).
// Expected {buzzerpin, active_sensor, busy} per cycle is queued when stimulus is applied
// and popped one entry per cycle, sampled on the falling edge.
module tb_sensor_buzzer_scheduler;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int GAP = 5;
`ifdef STICK_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         tests = 0;
    int         fails = 0;
    logic [3:0] sb[$];
    logic [3:0] got, exp;

    sensor_buzzer_scheduler_if bus();
    sensor_buzzer_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void push_idle(int n);
        repeat (n) sb.push_back(4'b0000);
    endfunction

    function automatic void push_burst(int idx);
        logic [1:0] a = 2'(idx);
        for (int b = 0; b < idx; b++) begin
            repeat (ON) sb.push_back({1'b1, a, 1'b1});
            repeat (OFF) sb.push_back({1'b0, a, 1'b1});
        end
        repeat (GAP) sb.push_back({1'b0, a, 1'b1});
    endfunction

    function automatic string fmt(logic [3:0] g, logic [3:0] e);
        return $sformatf("got buzz=%b act=%0d busy=%b, want buzz=%b act=%0d busy=%b",
                         g[3], g[2:1], g[0], e[3], e[2:1], e[0]);
    endfunction

    task automatic sample(output logic [3:0] g, output logic [3:0] e);
        @(negedge clk);
        g = {bus.buzzerpin, bus.active_sensor, bus.busy};
        e = sb.pop_front();
    endtask

    task automatic set_sensors(logic s1, logic s2, logic s3);
        bus.sensorpin1 = s1;
        bus.sensorpin2 = s2;
        bus.sensorpin3 = s3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_sensors(0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        set_sensors(0, 0, 0);
        #1 rst = 1'b1;
        #1;
        tests++;
        if (bus.buzzerpin !== 1'b0) begin fails++; $display("FAIL reset_buzz: got %b want 0", bus.buzzerpin); end
        tests++;
        if (bus.active_sensor !== 2'd0) begin fails++; $display("FAIL reset_active: got %0d want 0", bus.active_sensor); end
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_idle(5);
        for (int k = 0; sb.size() > 0; k++) begin
            sample(got, exp);
            tests++;
            if (got !== exp) begin fails++; $display("FAIL reset_idle step %0d: %s", k, fmt(got, exp)); end
        end
    endtask

    task automatic test_sensor3_repeat();
        set_sensors(0, 0, 1);
        push_idle(LAT);
        push_burst(3);
        push_idle(1);
        push_burst(3);
        for (int k = 0; sb.size() > 0; k++) begin
            sample(got, exp);
            tests++;
            if (got !== exp) begin fails++; $display("FAIL sensor3_repeat step %0d: %s", k, fmt(got, exp)); end
        end
        do_reset();
    endtask

    task automatic test_priority();
        set_sensors(1, 1, 0);
        push_idle(LAT);
        push_burst(1);
        push_idle(1);
        push_burst(2);
        for (int k = 0; k < LAT + ON; k++) begin
            sample(got, exp);
            tests++;
            if (got !== exp) begin fails++; $display("FAIL priority_first step %0d: %s", k, fmt(got, exp)); end
        end
        bus.sensorpin1 = 1'b0;
        for (int k = 0; sb.size() > 0; k++) begin
            sample(got, exp);
            tests++;
            if (got !== exp) begin fails++; $display("FAIL priority_second step %0d: %s", k, fmt(got, exp)); end
        end
        do_reset();
    endtask

`ifdef STICK_DEBOUNCE_EN
    task automatic test_glitch();
        set_sensors(0, 1, 0);
        push_idle(15);
        for (int k = 0; k < 3; k++) begin
            sample(got, exp);
            tests++;
            if (got !== exp) begin fails++; $display("FAIL glitch_high step %0d: %s", k, fmt(got, exp)); end
        end
        bus.sensorpin2 = 1'b0;
        for (int k = 0; sb.size() > 0; k++) begin
            sample(got, exp);
            tests++;
            if (got !== exp) begin fails++; $display("FAIL glitch_after step %0d: %s", k, fmt(got, exp)); end
        end
        do_reset();
    endtask
`endif

    task automatic test_no_preempt();
        set_sensors(0, 0, 1);
        push_idle(LAT);
        push_burst(3);
        push_idle(1);
        push_burst(1);
        for (int k = 0; k < LAT + ON + OFF + 1; k++) begin
            sample(got, exp);
            tests++;
            if (got !== exp) begin fails++; $display("FAIL preempt_before step %0d: %s", k, fmt(got, exp)); end
        end
        bus.sensorpin1 = 1'b1;
        for (int k = 0; sb.size() > 0; k++) begin
            sample(got, exp);
            tests++;
            if (got !== exp) begin fails++; $display("FAIL preempt_after step %0d: %s", k, fmt(got, exp)); end
        end
        do_reset();
    endtask

    task automatic test_async_reset();
        set_sensors(0, 1, 0);
        push_idle(LAT);
        push_burst(2);
        for (int k = 0; k < LAT + 1; k++) begin
            sample(got, exp);
            tests++;
            if (got !== exp) begin fails++; $display("FAIL async_pre step %0d: %s", k, fmt(got, exp)); end
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (bus.buzzerpin !== 1'b0) begin fails++; $display("FAIL async_buzz: got %b want 0", bus.buzzerpin); end
        tests++;
        if (bus.active_sensor !== 2'd0) begin fails++; $display("FAIL async_active: got %0d want 0", bus.active_sensor); end
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL async_busy: got %b want 0", bus.busy); end
        sb.delete();
        set_sensors(0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        push_idle(10);
        for (int k = 0; sb.size() > 0; k++) begin
            sample(got, exp);
            tests++;
            if (got !== exp) begin fails++; $display("FAIL async_post step %0d: %s", k, fmt(got, exp)); end
        end
    endtask

    initial begin
        test_reset();
        test_sensor3_repeat();
        test_priority();
`ifdef STICK_DEBOUNCE_EN
        test_glitch();
`endif
        test_no_preempt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
